// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode definitions: default field widths and the packed queue entry layout.
// The same header is used by fetch and every decode stage.
package fetch_decode_queue_pkg;

   localparam int unsigned FdqAddressWidth            = 64;
   localparam int unsigned FdqInstructionWidth        = 32;
   localparam int unsigned FdqPidSize                 = 20;
   localparam int unsigned FdqTidSize                 = 16;
   localparam int unsigned FdqInstructionCounterWidth = 64;

   // Field order is fixed; the queue packs and unpacks entries in exactly this order.
   typedef struct packed {
      logic [FdqInstructionWidth-1:0]        instruction;
      logic [FdqAddressWidth-1:0]            address;
      logic [FdqPidSize-1:0]                 pid;
      logic [FdqTidSize-1:0]                 tid;
      logic [FdqInstructionCounterWidth-1:0] maj_id;
   } fdq_entry_t;

   localparam int unsigned FdqEntryWidth = $bits(fdq_entry_t);

endpackage

// File: rtl/fetch_queue_storage.sv
// Depth x Width register array with one synchronous write port and an asynchronous head read.
// Holds data only; pointer and count bookkeeping live in the parent.
module fetch_queue_storage #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [Width-1:0]         rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: stamps each accepted instruction with a unique major ID
// and presents the head through registered outputs that hold while decode is stalled.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int unsigned addressWidth            = FdqAddressWidth,
   parameter int unsigned instructionWidth        = FdqInstructionWidth,
   parameter int unsigned PidSize                 = FdqPidSize,
   parameter int unsigned TidSize                 = FdqTidSize,
   parameter int unsigned instructionCounterWidth = FdqInstructionCounterWidth,
   parameter int unsigned queueDepth              = 8
) (
   input  logic                                 clock_i,
   input  logic                                 resetn_i,
   input  logic                                 flush_i,
   input  logic                                 fetchEnable_i,
   input  logic [instructionWidth-1:0]          instruction_i,
   input  logic [addressWidth-1:0]              instructionAddress_i,
   input  logic [PidSize-1:0]                   instructionPid_i,
   input  logic [TidSize-1:0]                   instructionTid_i,
   input  logic                                 decodeStall_i,
   output logic                                 fetchStall_o,
   output logic                                 outputEnable_o,
   output logic [instructionWidth-1:0]          instruction_o,
   output logic [addressWidth-1:0]              instructionAddress_o,
   output logic [PidSize-1:0]                   instructionPid_o,
   output logic [TidSize-1:0]                   instructionTid_o,
   output logic [instructionCounterWidth-1:0]   instructionMajId_o,
   output logic [$clog2(queueDepth+1)-1:0]      occupancy_o
);

   localparam int unsigned PtrW   = $clog2(queueDepth);
   localparam int unsigned CntW   = $clog2(queueDepth + 1);
   localparam int unsigned EntryW = instructionWidth + addressWidth + PidSize + TidSize +
                                    instructionCounterWidth;

   logic [PtrW-1:0]                    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]                    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]                    count_q, count_d;
   logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
   logic [EntryW-1:0]                  out_q, out_d;
   logic                               out_en_q, out_en_d;
   logic [EntryW-1:0]                  wr_entry;
   logic [EntryW-1:0]                  head_entry;
   logic                               full;
   logic                               push;
   logic                               pop;

   assign full     = (count_q == CntW'(queueDepth));
   assign wr_entry = {instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i,
                      maj_id_q};

   fetch_queue_storage #(
      .Depth (queueDepth),
      .Width (EntryW)
   ) u_storage (
      .clk_i   (clock_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_entry)
   );

   always_comb begin
      push     = fetchEnable_i && !full && !flush_i;
      pop      = !decodeStall_i && !flush_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      out_d    = out_q;
      out_en_d = out_en_q;
      // The ID counter survives flushes so IDs stay unique across redirects.
      maj_id_d = push ? maj_id_q + instructionCounterWidth'(1) : maj_id_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         out_en_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
         if (!decodeStall_i) begin
            out_en_d = pop;
            if (pop) out_d = head_entry;
         end
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         maj_id_q <= '0;
         out_q    <= '0;
         out_en_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         maj_id_q <= maj_id_d;
         out_q    <= out_d;
         out_en_q <= out_en_d;
      end
   end

   assign fetchStall_o   = full;
   assign outputEnable_o = out_en_q;
   assign occupancy_o    = count_q;
   assign {instruction_o, instructionAddress_o, instructionPid_o, instructionTid_o,
           instructionMajId_o} = out_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised and directed bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

   localparam int unsigned Depth = 8;

   typedef struct packed {
      logic [31:0] ins;
      logic [63:0] addr;
      logic [19:0] pid;
      logic [15:0] tid;
      logic [63:0] maj;
   } ent_t;

   logic        clock_i = 1'b0;
   logic        resetn_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        fetchEnable_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic [63:0] instructionAddress_i = '0;
   logic [19:0] instructionPid_i = '0;
   logic [15:0] instructionTid_i = '0;
   logic        decodeStall_i = 1'b0;
   logic        fetchStall_o;
   logic        outputEnable_o;
   logic [31:0] instruction_o;
   logic [63:0] instructionAddress_o;
   logic [19:0] instructionPid_o;
   logic [15:0] instructionTid_o;
   logic [63:0] instructionMajId_o;
   logic [3:0]  occupancy_o;

   fetch_decode_queue #(
      .queueDepth (Depth)
   ) dut (
      .clock_i              (clock_i),
      .resetn_i             (resetn_i),
      .flush_i              (flush_i),
      .fetchEnable_i        (fetchEnable_i),
      .instruction_i        (instruction_i),
      .instructionAddress_i (instructionAddress_i),
      .instructionPid_i     (instructionPid_i),
      .instructionTid_i     (instructionTid_i),
      .decodeStall_i        (decodeStall_i),
      .fetchStall_o         (fetchStall_o),
      .outputEnable_o       (outputEnable_o),
      .instruction_o        (instruction_o),
      .instructionAddress_o (instructionAddress_o),
      .instructionPid_o     (instructionPid_o),
      .instructionTid_o     (instructionTid_o),
      .instructionMajId_o   (instructionMajId_o),
      .occupancy_o          (occupancy_o)
   );

   always #5 clock_i = ~clock_i;

   // Reference model: FIFO of entries, next ID, and the last presented entry.
   ent_t        mq[$];
   logic [63:0] m_maj;
   ent_t        m_out;
   bit          m_en;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, check at the next negedge.
   task automatic cycle(input bit fen, input logic [31:0] ins, input bit stall, input bit fl);
      ent_t e;
      bit   full;
      fetchEnable_i        = fen;
      instruction_i        = ins;
      instructionAddress_i = {$urandom, $urandom};
      instructionPid_i     = 20'($urandom);
      instructionTid_i     = 16'($urandom);
      decodeStall_i        = stall;
      flush_i              = fl;
      full = (mq.size() == Depth);
      if (fl) begin
         mq.delete();
         m_en = 1'b0;
      end else begin
         if (!stall) begin
            if (mq.size() > 0) begin
               m_out = mq.pop_front();
               m_en  = 1'b1;
            end else begin
               m_en = 1'b0;
            end
         end
         if (fen && !full) begin
            e.ins  = ins;
            e.addr = instructionAddress_i;
            e.pid  = instructionPid_i;
            e.tid  = instructionTid_i;
            e.maj  = m_maj;
            mq.push_back(e);
            m_maj++;
         end
      end
      @(posedge clock_i);
      @(negedge clock_i);
      check_eq("occupancy", 64'(occupancy_o), 64'(mq.size()));
      check_eq("fetch_stall", 64'(fetchStall_o), 64'(mq.size() == Depth));
      check_eq("out_en", 64'(outputEnable_o), 64'(m_en));
      if (m_en) begin
         check_eq("instr", 64'(instruction_o), 64'(m_out.ins));
         check_eq("addr", instructionAddress_o, m_out.addr);
         check_eq("pid", 64'(instructionPid_o), 64'(m_out.pid));
         check_eq("tid", 64'(instructionTid_o), 64'(m_out.tid));
         check_eq("maj_id", instructionMajId_o, m_out.maj);
      end
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      fetchEnable_i = 1'b0;
      flush_i       = 1'b0;
      decodeStall_i = 1'b0;
      #2 resetn_i = 1'b0;
      #1;
      check_eq("rst_out_en", 64'(outputEnable_o), 64'd0);
      check_eq("rst_occ", 64'(occupancy_o), 64'd0);
      check_eq("rst_fstall", 64'(fetchStall_o), 64'd0);
      check_eq("rst_instr", 64'(instruction_o), 64'd0);
      check_eq("rst_maj", instructionMajId_o, 64'd0);
      mq.delete();
      m_maj = '0;
      m_out = '0;
      m_en  = 1'b0;
      @(negedge clock_i);
      @(negedge clock_i);
      resetn_i = 1'b1;
   endtask

   initial begin
      logic [31:0] x9;
      logic [31:0] prog [3];
      prog[0] = 32'h4800_0000;
      prog[1] = 32'h3860_0001;
      prog[2] = 32'h7C08_02A6;

      // In-order delivery with 1-cycle latency
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, prog[i], 1'b0, 1'b0);
         if (i > 0) check_eq("t1_maj", instructionMajId_o, 64'(i - 1));
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t1_maj2", instructionMajId_o, 64'd2);
      check_eq("t1_ins2", 64'(instruction_o), 64'h7C08_02A6);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t1_en_low", 64'(outputEnable_o), 64'd0);

      // Fill under stall, full back-pressure, ninth accepted after first pop
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
      check_eq("t2_occ8", 64'(occupancy_o), 64'd8);
      check_eq("t2_full", 64'(fetchStall_o), 64'd1);
      x9 = 32'hDEAD_0009;
      cycle(1'b1, x9, 1'b1, 1'b0);
      check_eq("t2_held", 64'(occupancy_o), 64'd8);
      cycle(1'b1, x9, 1'b0, 1'b0);
      check_eq("t2_pop_occ", 64'(occupancy_o), 64'd7);
      check_eq("t2_pop_maj", instructionMajId_o, 64'd0);
      cycle(1'b1, x9, 1'b0, 1'b0);
      check_eq("t2_acc_occ", 64'(occupancy_o), 64'd7);
      for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t2_9th_maj", instructionMajId_o, 64'd8);
      check_eq("t2_9th_ins", 64'(instruction_o), 64'(x9));

      // Output hold across a 4-cycle stall
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, prog[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         check_eq("t3_hold_ins", 64'(instruction_o), 64'h3860_0001);
         check_eq("t3_hold_maj", instructionMajId_o, 64'd1);
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t3_next", 64'(instruction_o), 64'h7C08_02A6);

      // Flush with a simultaneous push: push dropped, ID not consumed
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
      cycle(1'b1, $urandom, 1'b1, 1'b1);
      check_eq("t4_occ0", 64'(occupancy_o), 64'd0);
      check_eq("t4_en0", 64'(outputEnable_o), 64'd0);
      cycle(1'b1, 32'h6000_0000, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t4_maj5", instructionMajId_o, 64'd5);

      // Asynchronous reset mid-stream, IDs restart at 0
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
      do_reset();
      cycle(1'b1, 32'h3800_0007, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t5_maj0", instructionMajId_o, 64'd0);

      // 20 back-to-back transfers wrap the pointers
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, $urandom, 1'b0, 1'b0);
         check_eq("t6_occ_le1", 64'(occupancy_o <= 4'd1), 64'd1);
         if (i > 0) check_eq("t6_maj", instructionMajId_o, 64'(i - 1));
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t6_maj19", instructionMajId_o, 64'd19);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 31) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch unit and the format-scan decode stage.
- Buffers fetched instructions together with address, PID and TID, and stamps each accepted instruction with a unique major ID.
- Presents one instruction per cycle through registered outputs that the format scan samples when it is not stalled.
- Absorbs decode back-pressure and applies back-pressure to fetch when full.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, POWER fixed instruction width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID counter width
- queueDepth, 8, entry count; must be a power of two and at least 2

Ports:
- clock_i  in  1  clock
- resetn_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous flush, e.g. on branch redirect
- fetchEnable_i  in  1  fetch presents a valid instruction this cycle
- instruction_i  in  instructionWidth  instruction word, bit 0 = MSB
- instructionAddress_i  in  addressWidth  instruction address
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- decodeStall_i  in  1  downstream stall; outputs must hold
- fetchStall_o  out  1  queue full; fetch must hold its instruction
- outputEnable_o  out  1  output instruction valid
- instruction_o  out  instructionWidth  head instruction
- instructionAddress_o  out  addressWidth  head address
- instructionPid_o  out  PidSize  head PID
- instructionTid_o  out  TidSize  head TID
- instructionMajId_o  out  instructionCounterWidth  major ID of the head instruction
- occupancy_o  out  clog2(queueDepth+1)  entries currently stored

Behaviour:
- Reset (resetn_i low, asynchronous):
  - all outputs 0, including fetchStall_o and outputEnable_o
  - read/write pointers, count and major ID counter = 0
- Enqueue:
  - accept = fetchEnable_i && !fetchStall_o && !flush_i.
  - The entry stores the inputs plus the current major ID counter value.
  - The counter increments by 1 per accept only, wrapping modulo 2^instructionCounterWidth.
- fetchStall_o = (count == queueDepth), derived from the registered count.
  - A pop in the same cycle does not allow a push when full; the push is accepted the next cycle.
- Output stage, evaluated every edge with !decodeStall_i and !flush_i:
  - count > 0: load head into the output registers, set outputEnable_o = 1, pop (read pointer +1 mod queueDepth).
  - count == 0: set outputEnable_o = 0; data outputs may hold stale values.
- While decodeStall_i is high:
  - output registers and outputEnable_o hold unchanged
  - no pop occurs
  - enqueue continues until full
- Latency:
  - An instruction accepted into an empty queue at edge N appears on the outputs after edge N+1, provided edge N+1 is unstalled.
  - Sustained throughput is 1 instruction per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push into an empty queue does not bypass into the output in the same edge.
- Flush (synchronous, highest priority):
  - count, pointers, outputEnable_o and occupancy_o go to 0
  - a simultaneous push is dropped and no pop occurs
  - the major ID counter is NOT cleared, so IDs stay unique across flushes
  - flush overrides decodeStall_i
- Reset mid-operation discards all contents immediately, including the output registers.
- Pointers use log2(queueDepth) bits and wrap naturally. count uses clog2(queueDepth+1) bits and never exceeds queueDepth or goes below 0.

Decomposition:
- Shared package/header: addressWidth, instructionWidth, PidSize, TidSize, instructionCounterWidth defaults, plus the packed entry layout {instruction, address, pid, tid, majId}. The same header serves fetch and all decode stages.
- One sub-module: fetch_queue_storage, a parameterised depth × entry-width register array with a write port (pointer, enable) and an asynchronous read of the head. Pointer/count logic stays in the parent.

Test Plan:
- Reset, then push 3 instructions (0x48000000, 0x38600001, 0x7C0802A6) on consecutive cycles with decodeStall_i = 0:
  - outputs show them in order on cycles 2, 3, 4
  - MajIds are 0, 1, 2
  - outputEnable_o falls to 0 the cycle after the third
- Hold decodeStall_i = 1, push 8 instructions:
  - fetchStall_o = 1 after the 8th and occupancy_o = 8
  - a 9th push held on fetchEnable_i is not accepted
  - release the stall: the 9th is accepted one cycle after the first pop, and its MajId is 8
- Stall while outputEnable_o = 1 with instruction 0x38600001 on the outputs for 4 cycles: all outputs are stable for all 4 cycles and the next instruction appears the cycle after release.
- Queue holding 5 entries, assert flush_i together with fetchEnable_i:
  - next cycle occupancy_o = 0, outputEnable_o = 0
  - the next accepted push gets MajId 5 (the flush-cycle push was dropped and did not consume an ID)
- Assert resetn_i low asynchronously mid-stream between clock edges: all outputs go to 0 immediately, without waiting for a clock edge; after release, the first push gets MajId 0.
- Run 20 back-to-back pushes and pops with queueDepth = 8: pointer wrap is exercised, order and MajIds 0 to 19 are preserved, and occupancy_o never exceeds 1.
